rand_stream_gen: RTL and testbench
==================================

Name: rand_stream_gen

Overview:
- Hardware pseudo-random stimulus source that produces rand_byte, rand_int and rand_nibble sample triples.
- Samples come from a 32-bit Galois LFSR and are delivered over a valid/ready handshake.
- It emits a fixed-length burst of NUM_SAMPLES samples per start, then raises done.
- It is the producer side of the randomize-and-check flow: the existing assertion-based checker benches consume its samples, so the checker no longer calls the randomizer itself.

Parameters:
- NUM_SAMPLES, 10: samples per burst; legal range 1..65535; 0 is illegal.
- SEED, 32'h0000_0001: LFSR value after reset; must be nonzero.
- NONNEG_INT, 0: when 1, force rand_int[31]=0 on every sample.
- BYTE_LT128, 0: when 1, force rand_byte[7]=0 on every sample.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a burst; honoured only in IDLE or DONE
- seed_load  in  1  load seed_in into LFSR; honoured only in IDLE or DONE
- seed_in  in  32  seed value
- ready  in  1  consumer accepts the current sample
- valid  out  1  sample outputs hold a valid sample
- rand_byte  out  8  byte field
- rand_int  out  32  int field
- rand_nibble  out  4  nibble field
- sample_idx  out  16  index of the presented sample, 0-based
- done  out  1  burst complete; level signal

Behaviour:
- Reset (async assert, sync release): lfsr=SEED, state=IDLE; valid, done, rand_byte, rand_int, rand_nibble and sample_idx all =0.
- Reset mid-burst abandons the burst immediately; no partial handshake is completed.
- LFSR step: nxt = (lfsr>>1) ^ (lfsr[0] ? 32'h8020_0003 : 0).
- The LFSR advances only when a sample is generated.
- Field mapping, taken from nxt: rand_int=nxt; rand_byte=nxt[31:24]^nxt[7:0]; rand_nibble=nxt[15:12]. Masks are applied after mapping.
- All outputs are registered; there is no combinational path from ready to valid.
- States: IDLE, GEN, SEND, DONE.
- IDLE:
  - seed_load=1 sets lfsr=seed_in; seed_in==0 loads 32'h1 instead.
  - If seed_load and start are both high, the seed loads first and the burst uses the new seed.
  - start -> GEN, with count=0 and done=0.
- GEN: one cycle. LFSR steps, fields are captured, sample_idx=0, valid=1, go to SEND.
- Latency: start sampled at edge k -> valid=1 after edge k+1.
- SEND:
  - Outputs hold stable while valid && !ready.
  - On valid && ready with count < NUM_SAMPLES-1: step the LFSR and capture the next sample on the same edge. valid stays 1, sample_idx increments. Throughput is 1 sample/cycle.
  - On valid && ready with count == NUM_SAMPLES-1: valid=0, done=1, go to DONE.
  - Field outputs keep their last values after valid falls.
- DONE:
  - done is held.
  - seed_load behaves as in IDLE.
  - start -> GEN, clears done, restarts count. The LFSR continues from its current state; it is not reseeded.
- start or seed_load while in GEN or SEND is ignored.
- ready while valid=0 is ignored.
- NUM_SAMPLES=1: a single handshake goes straight to DONE.
- The LFSR never reaches 0: a nonzero seed is guaranteed by the seed_in==0 substitution and the SEED rule.

Test Plan:
1. Reset with seed_in=1, seed_load+start together, ready=1 -> sample0 rand_int=0x80200003, rand_byte=0x83, rand_nibble=0; sample1 rand_int=0xC0300002, rand_byte=0xC2, rand_nibble=0.
2. Same stimulus with NONNEG_INT=1, BYTE_LT128=1 -> sample0 rand_int=0x00200003, rand_byte=0x03.
3. Hold ready=0 for 5 cycles after valid, then pulse it -> outputs and sample_idx stable throughout; one accepted sample; sample_idx increments by exactly 1.
4. NUM_SAMPLES=10, ready=1 continuously -> 10 consecutive valid cycles with sample_idx 0..9; done=1 the cycle after the 10th accept; a start pulse mid-burst has no effect.
5. Assert reset_n low during SEND at sample_idx=4 -> valid=0 and all outputs 0 immediately (asynchronously); a restart with seed 1 reproduces 0x80200003.
6. seed_load with seed_in=0 in DONE, then start -> first sample rand_int=0x80200003 (zero seed substituted with 1); done clears on start.

Source files
------------

// File: rtl/rand_stream_gen.sv
// Pseudo-random stimulus source: a 32-bit Galois LFSR feeds rand_byte/rand_int/rand_nibble
// samples over a valid/ready handshake, NUM_SAMPLES per start, then raises done.
module rand_stream_gen #(
  parameter int unsigned NUM_SAMPLES = 10,
  parameter logic [31:0] SEED        = 32'h0000_0001,
  parameter bit          NONNEG_INT  = 1'b0,
  parameter bit          BYTE_LT128  = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        seed_load,
  input  logic [31:0] seed_in,
  input  logic        ready,
  output logic        valid,
  output logic [7:0]  rand_byte,
  output logic [31:0] rand_int,
  output logic [3:0]  rand_nibble,
  output logic [15:0] sample_idx,
  output logic        done
);

  localparam logic [31:0] TAPS      = 32'h8020_0003;
  localparam logic [31:0] SEED_SAFE = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [15:0] LAST_IDX  = 16'(NUM_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, GEN, SEND, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] lfsr, lfsr_nxt;
  logic        capture, load_seed, begin_burst, finish;
  logic [31:0] map_int;
  logic [7:0]  map_byte;
  logic [3:0]  map_nibble;

  // Fields are taken from the stepped value, so a capture and the LFSR advance share one edge.
  always_comb begin
    lfsr_nxt   = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);
    map_int    = lfsr_nxt;
    map_byte   = lfsr_nxt[31:24] ^ lfsr_nxt[7:0];
    map_nibble = lfsr_nxt[15:12];
    if (NONNEG_INT) map_int[31]  = 1'b0;
    if (BYTE_LT128) map_byte[7]  = 1'b0;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    load_seed   = 1'b0;
    begin_burst = 1'b0;
    finish      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        load_seed = seed_load;
        if (start) begin
          begin_burst = 1'b1;
          state_next  = GEN;
        end
      end
      GEN: begin
        capture    = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        if (valid && ready) begin
          if (sample_idx == LAST_IDX) begin
            finish     = 1'b1;
            state_next = DONE;
          end else begin
            capture = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // sample_idx doubles as the burst counter; it restarts at 0 on the GEN capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr        <= SEED_SAFE;
      valid       <= 1'b0;
      done        <= 1'b0;
      rand_byte   <= 8'h0;
      rand_int    <= 32'h0;
      rand_nibble <= 4'h0;
      sample_idx  <= 16'h0;
    end else begin
      if (load_seed)    lfsr <= (seed_in == 32'h0) ? 32'h1 : seed_in;
      else if (capture) lfsr <= lfsr_nxt;

      if (capture) begin
        rand_int    <= map_int;
        rand_byte   <= map_byte;
        rand_nibble <= map_nibble;
        valid       <= 1'b1;
        sample_idx  <= (state == GEN) ? 16'h0 : sample_idx + 16'h1;
      end

      if (finish) begin
        valid <= 1'b0;
        done  <= 1'b1;
      end

      if (begin_burst) done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rand_stream_gen.sv
// Directed bench for rand_stream_gen: a vector table for the free-running burst plus
// hand-written stall, mid-burst reset and zero-seed restart sequences.
module tb_rand_stream_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, seed_load, ready;
  logic [31:0] seed_in;

  logic        valid, done;
  logic [7:0]  rand_byte;
  logic [31:0] rand_int;
  logic [3:0]  rand_nibble;
  logic [15:0] sample_idx;

  logic        b_valid, b_done;
  logic [7:0]  b_byte;
  logic [31:0] b_int;
  logic [3:0]  b_nibble;
  logic [15:0] b_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rand_stream_gen #(.NUM_SAMPLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .seed_load(seed_load),
    .seed_in(seed_in), .ready(ready), .valid(valid), .rand_byte(rand_byte),
    .rand_int(rand_int), .rand_nibble(rand_nibble), .sample_idx(sample_idx), .done(done)
  );

  // Masked variant with a single-sample burst.
  rand_stream_gen #(.NUM_SAMPLES(1), .NONNEG_INT(1'b1), .BYTE_LT128(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .seed_load(seed_load),
    .seed_in(seed_in), .ready(ready), .valid(b_valid), .rand_byte(b_byte),
    .rand_int(b_int), .rand_nibble(b_nibble), .sample_idx(b_idx), .done(b_done)
  );

  typedef struct {
    logic        start, seed_load, ready;
    logic        exp_valid, exp_done;
    logic [15:0] exp_idx;
    logic [31:0] exp_int;
    logic [7:0]  exp_byte;
    logic [3:0]  exp_nib;
    logic        chk_b;
    logic        b_valid, b_done;
    logic [31:0] b_int;
    logic [7:0]  b_byte;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_sample(input string tag, input logic [15:0] idx, input logic [31:0] i,
                              input logic [7:0] b, input logic [3:0] n);
    check({tag, " valid"},  32'(valid),       32'h1);
    check({tag, " idx"},    32'(sample_idx),  32'(idx));
    check({tag, " int"},    rand_int,         i);
    check({tag, " byte"},   32'(rand_byte),   32'(b));
    check({tag, " nibble"}, 32'(rand_nibble), 32'(n));
  endtask

  task automatic do_reset();
    start = 1'b0; seed_load = 1'b0; ready = 1'b0; seed_in = 32'h1;
    reset_n = 1'b0;
    #12;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    // {start, seed_load, ready, valid, done, idx, int, byte, nibble, chk_b, b_valid, b_done, b_int, b_byte}
    vecs[0]  = '{1, 1, 1, 0, 0, 16'd0, 32'h0000_0000, 8'h00, 4'h0, 1, 0, 0, 32'h0000_0000, 8'h00};
    vecs[1]  = '{0, 0, 1, 1, 0, 16'd0, 32'h8020_0003, 8'h83, 4'h0, 1, 1, 0, 32'h0020_0003, 8'h03};
    vecs[2]  = '{0, 0, 1, 1, 0, 16'd1, 32'hC030_0002, 8'hC2, 4'h0, 1, 0, 1, 32'h0020_0003, 8'h03};
    vecs[3]  = '{0, 0, 1, 1, 0, 16'd2, 32'h6018_0001, 8'h61, 4'h0, 0, 0, 0, 32'h0, 8'h0};
    vecs[4]  = '{1, 0, 1, 1, 0, 16'd3, 32'hB02C_0003, 8'hB3, 4'h0, 0, 0, 0, 32'h0, 8'h0};
    vecs[5]  = '{0, 0, 1, 1, 0, 16'd4, 32'hD836_0002, 8'hDA, 4'h0, 0, 0, 0, 32'h0, 8'h0};
    vecs[6]  = '{0, 0, 1, 1, 0, 16'd5, 32'h6C1B_0001, 8'h6D, 4'h0, 0, 0, 0, 32'h0, 8'h0};
    vecs[7]  = '{0, 0, 1, 1, 0, 16'd6, 32'hB62D_8003, 8'hB5, 4'h8, 0, 0, 0, 32'h0, 8'h0};
    vecs[8]  = '{0, 0, 1, 1, 0, 16'd7, 32'hDB36_C002, 8'hD9, 4'hC, 0, 0, 0, 32'h0, 8'h0};
    vecs[9]  = '{0, 0, 1, 1, 0, 16'd8, 32'h6D9B_6001, 8'h6C, 4'h6, 0, 0, 0, 32'h0, 8'h0};
    vecs[10] = '{0, 0, 1, 1, 0, 16'd9, 32'hB6ED_B003, 8'hB5, 4'hB, 0, 0, 0, 32'h0, 8'h0};
    vecs[11] = '{0, 0, 1, 0, 1, 16'd9, 32'hB6ED_B003, 8'hB5, 4'hB, 0, 0, 0, 32'h0, 8'h0};
    vecs[12] = '{0, 0, 1, 0, 1, 16'd9, 32'hB6ED_B003, 8'hB5, 4'hB, 0, 0, 0, 32'h0, 8'h0};

    // Reset state, checked while reset is held.
    start = 1'b0; seed_load = 1'b0; ready = 1'b0; seed_in = 32'h1;
    reset_n = 1'b0;
    #7;
    check("reset valid",  32'(valid),       32'h0);
    check("reset done",   32'(done),        32'h0);
    check("reset int",    rand_int,         32'h0);
    check("reset byte",   32'(rand_byte),   32'h0);
    check("reset nibble", 32'(rand_nibble), 32'h0);
    check("reset idx",    32'(sample_idx),  32'h0);
    #5;
    reset_n = 1'b1;
    tick();

    // Full burst with ready held high, including a mid-burst start that must be ignored.
    for (int i = 0; i < 13; i++) begin
      start = vecs[i].start; seed_load = vecs[i].seed_load; ready = vecs[i].ready;
      tick();
      check($sformatf("v%0d valid", i),  32'(valid),       32'(vecs[i].exp_valid));
      check($sformatf("v%0d done", i),   32'(done),        32'(vecs[i].exp_done));
      check($sformatf("v%0d idx", i),    32'(sample_idx),  32'(vecs[i].exp_idx));
      check($sformatf("v%0d int", i),    rand_int,         vecs[i].exp_int);
      check($sformatf("v%0d byte", i),   32'(rand_byte),   32'(vecs[i].exp_byte));
      check($sformatf("v%0d nibble", i), 32'(rand_nibble), 32'(vecs[i].exp_nib));
      if (vecs[i].chk_b) begin
        check($sformatf("v%0d b_valid", i), 32'(b_valid),  32'(vecs[i].b_valid));
        check($sformatf("v%0d b_done", i),  32'(b_done),   32'(vecs[i].b_done));
        check($sformatf("v%0d b_int", i),   b_int,         vecs[i].b_int);
        check($sformatf("v%0d b_byte", i),  32'(b_byte),   32'(vecs[i].b_byte));
      end
    end

    // Backpressure: outputs hold while ready is low, one pulse advances exactly one sample.
    do_reset();
    start = 1'b1; seed_load = 1'b1; seed_in = 32'h1; ready = 1'b0;
    tick();
    start = 1'b0; seed_load = 1'b0;
    tick();
    check_sample("stall first", 16'd0, 32'h8020_0003, 8'h83, 4'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_sample($sformatf("stall hold%0d", i), 16'd0, 32'h8020_0003, 8'h83, 4'h0);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check_sample("stall pulse", 16'd1, 32'hC030_0002, 8'hC2, 4'h0);
    tick();
    check_sample("stall after", 16'd1, 32'hC030_0002, 8'hC2, 4'h0);

    // Asynchronous reset in the middle of a burst at sample_idx 4.
    do_reset();
    start = 1'b1; seed_load = 1'b1; seed_in = 32'h1; ready = 1'b1;
    tick();
    start = 1'b0; seed_load = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_sample("pre-reset", 16'd4, 32'hD836_0002, 8'hDA, 4'h0);
    #3;
    reset_n = 1'b0;
    #1;
    check("async valid",  32'(valid),       32'h0);
    check("async int",    rand_int,         32'h0);
    check("async byte",   32'(rand_byte),   32'h0);
    check("async idx",    32'(sample_idx),  32'h0);
    check("async done",   32'(done),        32'h0);
    #8;
    reset_n = 1'b1;
    start = 1'b1; seed_load = 1'b1; seed_in = 32'h1; ready = 1'b0;
    tick();
    start = 1'b0; seed_load = 1'b0;
    tick();
    check_sample("restart", 16'd0, 32'h8020_0003, 8'h83, 4'h0);

    // Drain the burst, then load a zero seed in DONE and restart.
    ready = 1'b1;
    begin
      int n;
      n = 0;
      while (!done && n < 20) begin
        tick();
        n++;
      end
      check("drain done reached", 32'(done), 32'h1);
      check("drain accept count", 32'(n), 32'd10);
    end
    ready = 1'b0; seed_in = 32'h0; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("done held", 32'(done), 32'h1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("done cleared", 32'(done),  32'h0);
    check("gen valid",    32'(valid), 32'h0);
    tick();
    check_sample("zero seed", 16'd0, 32'h8020_0003, 8'h83, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
